// File: rtl/function_unit_seq_pkg.sv
// Shared definitions for the registered function unit: FS opcode map,
// controller state encoding and the V/C/N/Z flag bundle.
// The MUL state only exists when FU_MUL_EN is defined.
package fu_pkg;

    localparam logic [3:0] FS_PASSA  = 4'd0;
    localparam logic [3:0] FS_INCA   = 4'd1;
    localparam logic [3:0] FS_ADD    = 4'd2;
    localparam logic [3:0] FS_ADDC   = 4'd3;
    localparam logic [3:0] FS_ADDNB  = 4'd4;
    localparam logic [3:0] FS_SUB    = 4'd5;
    localparam logic [3:0] FS_DECA   = 4'd6;
    localparam logic [3:0] FS_PASSA2 = 4'd7;
    localparam logic [3:0] FS_AND    = 4'd8;
    localparam logic [3:0] FS_OR     = 4'd9;
    localparam logic [3:0] FS_XOR    = 4'd10;
    localparam logic [3:0] FS_NOTA   = 4'd11;
    localparam logic [3:0] FS_PASSB  = 4'd12;
    localparam logic [3:0] FS_SHRB   = 4'd13;
    localparam logic [3:0] FS_SHLB   = 4'd14;
    localparam logic [3:0] FS_MUL    = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef FU_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/function_unit_seq_if.sv
// Handshake/data bundle between the register-file read buses, the
// function unit and the write-back/flag register.
// slave = function unit side, master = producer/consumer side.
interface function_unit_seq_if #(parameter int WIDTH = 8);

    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] ABUS;
    logic [WIDTH-1:0] BBUS;
    logic [3:0]       FS;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] FS_OUT;
    logic             V;
    logic             C;
    logic             N;
    logic             Z;

    modport slave (
        input  IN_VALID, ABUS, BBUS, FS, OUT_READY,
        output IN_READY, OUT_VALID, FS_OUT, V, C, N, Z
    );

    modport master (
        output IN_VALID, ABUS, BBUS, FS, OUT_READY,
        input  IN_READY, OUT_VALID, FS_OUT, V, C, N, Z
    );

endinterface

// File: rtl/function_unit_seq_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after i_start, o_done pulses for one cycle with the full
// 2*WIDTH-bit product on o_product.
module fu_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic               r_done;

    // Latch operands on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (r_count == LAST_STEP) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/function_unit_seq.sv
// Registered WIDTH-bit function unit with valid/ready on both sides.
// Opcodes 0-14 complete in one cycle; opcode 15 is a WIDTH-step
// shift-add multiply when FU_MUL_EN is defined, otherwise B<<1.
module function_unit_seq
    import fu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    function_unit_seq_if.slave   bus
);

    state_t           r_state;
    logic             r_outValid;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    logic [WIDTH-1:0] w_addX;
    logic [WIDTH-1:0] w_addY;
    logic             w_cin;
    logic             w_isArith;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_aluRes;
    flags_t           w_aluFlags;
    logic             w_inReady;
    logic             w_accept;

    // Operand selection for the shared WIDTH+1-bit adder used by opcodes 1-6.
    always_comb begin
        w_addX    = bus.ABUS;
        w_addY    = '0;
        w_cin     = 1'b0;
        w_isArith = 1'b1;
        case (bus.FS)
            FS_INCA:  w_cin = 1'b1;
            FS_ADD:   w_addY = bus.BBUS;
            FS_ADDC:  begin w_addY = bus.BBUS; w_cin = 1'b1; end
            FS_ADDNB: w_addY = ~bus.BBUS;
            FS_SUB:   begin w_addY = ~bus.BBUS; w_cin = 1'b1; end
            FS_DECA:  w_addY = '1;
            default:  w_isArith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_addX} + {1'b0, w_addY} + {{WIDTH{1'b0}}, w_cin};

    // Single-cycle result and flags; opcode 15 falls through to B<<1 here.
    always_comb begin
        w_aluRes     = '0;
        w_aluFlags   = '0;
        if (w_isArith) begin
            w_aluRes     = w_sum[WIDTH-1:0];
            w_aluFlags.c = w_sum[WIDTH];
            w_aluFlags.v = (w_addX[WIDTH-1] == w_addY[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != w_addX[WIDTH-1]);
        end else begin
            case (bus.FS)
                FS_AND:   w_aluRes = bus.ABUS & bus.BBUS;
                FS_OR:    w_aluRes = bus.ABUS | bus.BBUS;
                FS_XOR:   w_aluRes = bus.ABUS ^ bus.BBUS;
                FS_NOTA:  w_aluRes = ~bus.ABUS;
                FS_PASSB: w_aluRes = bus.BBUS;
                FS_SHRB:  begin
                    w_aluRes     = {1'b0, bus.BBUS[WIDTH-1:1]};
                    w_aluFlags.c = bus.BBUS[0];
                end
                FS_SHLB, FS_MUL: begin
                    w_aluRes     = {bus.BBUS[WIDTH-2:0], 1'b0};
                    w_aluFlags.c = bus.BBUS[WIDTH-1];
                end
                default:  w_aluRes = bus.ABUS;
            endcase
        end
        w_aluFlags.n = w_aluRes[WIDTH-1];
        w_aluFlags.z = (w_aluRes == '0);
    end

`ifdef FU_MUL_EN
    logic               w_mulStart;
    logic               w_mulDone;
    logic [2*WIDTH-1:0] w_mulProd;
    flags_t             w_mulFlags;

    assign w_mulStart = w_accept && (bus.FS == FS_MUL);

    fu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_start   (w_mulStart),
        .i_a       (bus.ABUS),
        .i_b       (bus.BBUS),
        .o_done    (w_mulDone),
        .o_product (w_mulProd)
    );

    // Truncated product flags: any lost high bit sets both carry and overflow.
    always_comb begin
        w_mulFlags   = '0;
        w_mulFlags.c = |w_mulProd[2*WIDTH-1:WIDTH];
        w_mulFlags.v = |w_mulProd[2*WIDTH-1:WIDTH];
        w_mulFlags.n = w_mulProd[WIDTH-1];
        w_mulFlags.z = (w_mulProd[WIDTH-1:0] == '0);
    end
`endif

    // Ready in IDLE, or in HOLD when the current result is being taken; never during reset.
    always_comb begin
        w_inReady = 1'b0;
        if (!RST) begin
            case (r_state)
                ST_IDLE: w_inReady = 1'b1;
                ST_HOLD: w_inReady = bus.OUT_READY;
                default: w_inReady = 1'b0;
            endcase
        end
    end

    assign w_accept = bus.IN_VALID && w_inReady;

    // Controller: accept, run multiply, hold result until the consumer takes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HOLD: begin
                    if (w_accept) begin
`ifdef FU_MUL_EN
                        if (bus.FS == FS_MUL) begin
                            r_state    <= ST_MUL;
                            r_outValid <= 1'b0;
                        end else
`endif
                        begin
                            r_state    <= ST_HOLD;
                            r_outValid <= 1'b1;
                            r_result   <= w_aluRes;
                            r_flags    <= w_aluFlags;
                        end
                    end else if ((r_state == ST_HOLD) && bus.OUT_READY) begin
                        r_state    <= ST_IDLE;
                        r_outValid <= 1'b0;
                    end
                end
`ifdef FU_MUL_EN
                ST_MUL: begin
                    if (w_mulDone) begin
                        r_state    <= ST_HOLD;
                        r_outValid <= 1'b1;
                        r_result   <= w_mulProd[WIDTH-1:0];
                        r_flags    <= w_mulFlags;
                    end
                end
`endif
                default: begin
                    r_state    <= ST_IDLE;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IN_READY  = w_inReady;
    assign bus.OUT_VALID = r_outValid;
    assign bus.FS_OUT    = r_result;
    assign bus.V         = r_flags.v;
    assign bus.C         = r_flags.c;
    assign bus.N         = r_flags.n;
    assign bus.Z         = r_flags.z;

endmodule
